// File: rtl/seq_logic_shifter.sv
// seq_logic_shifter: multi-cycle logical/rotate shifter, one bit position per clock over valid/ready
module seq_logic_shifter #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] di,
   input  logic [SHW-1:0]   amt,
   input  logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] so,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] so_q, so_d;
   logic [SHW-1:0]   cnt_q;
   logic [1:0]       mode_q;
   logic             in_ready_q, out_valid_q, busy_q;
   // mode: 00 lsl, 01 lsr, 10 rol, 11 ror; rotates recirculate the exiting bit
   always_comb
      so_d = mode_q == 2'b00 ? {so_q[WIDTH-2:0], 1'b0} :
             mode_q == 2'b01 ? {1'b0, so_q[WIDTH-1:1]} :
             mode_q == 2'b10 ? {so_q[WIDTH-2:0], so_q[WIDTH-1]} :
                               {so_q[0], so_q[WIDTH-1:1]};
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         so_q        <= '0;
         cnt_q       <= '0;
         mode_q      <= 2'b00;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               so_q       <= di;
               mode_q     <= sel;
               cnt_q      <= amt;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b1;
               if (amt == '0) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               so_q  <= so_d;
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign so        = so_q;
endmodule

// File: tb/tb_seq_logic_shifter.sv
// tb_seq_logic_shifter: directed-vector self-checking bench for seq_logic_shifter
module tb_seq_logic_shifter;
   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready;
   logic [7:0] di;
   logic [2:0] amt;
   logic [1:0] sel;
   logic       in_ready, out_valid, busy;
   logic [7:0] so;
   int         n_checks = 0;
   int         n_fail   = 0;

   seq_logic_shifter #(.WIDTH(8), .SHW(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .di(di), .amt(amt), .sel(sel), .out_valid(out_valid),
      .out_ready(out_ready), .so(so), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref1(input logic [7:0] d, input logic [1:0] s);
      logic [7:0] r;
      case (s)
         2'd0: r = d << 1;
         2'd1: r = d >> 1;
         2'd2: r = (d << 1) | (d >> 7);
         default: r = (d >> 1) | (d << 7);
      endcase
      return r;
   endfunction

   task automatic run(input string tag, input logic [7:0] d, input logic [2:0] a,
                      input logic [1:0] s, input logic [7:0] exp);
      int lat;
      in_valid = 1'b1; di = d; amt = a; sel = s; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; di = ~d; amt = 3'd5; sel = ~s;
      check({tag, " busy"}, busy, 1);
      check({tag, " in_ready low"}, in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, a);
      check({tag, " so"}, so, exp);
      tick();
      check({tag, " out_valid drop"}, out_valid, 0);
      check({tag, " in_ready back"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; di = 8'hFF; amt = 3'd2; sel = 2'b00;
      tick();
      tick();
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset so", so, 8'h00);
      rst = 1'b0; in_valid = 1'b0;
      tick();

      run("lsl3", 8'b1001_0110, 3'd3, 2'b00, 8'b1011_0000);
      run("lsr3", 8'b1001_0110, 3'd3, 2'b01, 8'b0001_0010);
      run("rol3", 8'b1001_0110, 3'd3, 2'b10, 8'b1011_0100);
      run("ror1", 8'b1001_0110, 3'd1, 2'b11, 8'b0100_1011);
      run("rol7", 8'b1000_0001, 3'd7, 2'b10, 8'b1100_0000);
      run("ror7", 8'b1000_0011, 3'd7, 2'b11, 8'b0000_0111);
      for (int s = 0; s < 4; s++) run("amt0", 8'hA5, 3'd0, 2'(s), 8'hA5);

      // backpressure: result must hold and new requests must be ignored
      in_valid = 1'b1; di = 8'h01; amt = 3'd7; sel = 2'b00; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp latency", lat, 7);
      in_valid = 1'b1; di = 8'h33; amt = 3'd2; sel = 2'b01;
      for (int i = 0; i < 5; i++) begin
         check("bp so", so, 8'h80);
         check("bp out_valid", out_valid, 1);
         check("bp in_ready", in_ready, 0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("bp done out_valid", out_valid, 0);
      check("bp done in_ready", in_ready, 1);
      tick();
      check("bp no accept busy", busy, 0);
      check("bp no accept so", so, 8'h80);

      // reset in the middle of a 7-step shift
      in_valid = 1'b1; di = 8'hFF; amt = 3'd7; sel = 2'b10;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("mid busy", busy, 1);
      rst = 1'b1; in_valid = 1'b1;
      tick();
      check("mid rst so", so, 8'h00);
      check("mid rst out_valid", out_valid, 0);
      check("mid rst busy", busy, 0);
      check("mid rst in_ready", in_ready, 1);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check("mid rst idle", busy, 0);
      run("post rst lsr4", 8'hFF, 3'd4, 2'b01, 8'h0F);

      for (int s = 0; s < 4; s++)
         for (int d = 1; d <= 8; d++)
            run("walk", 8'(d), 3'd1, 2'(s), ref1(8'(d), 2'(s)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/seq_logic_shifter.md
Name: seq_logic_shifter

Overview:
Multi-cycle sequential counterpart of the team's combinational logic shifter. It accepts a data word, a shift amount and a mode over a valid/ready input handshake, and shifts one bit position per clock. It returns the result over a valid/ready output handshake. It sits in datapaths where a full barrel shifter is too large and multi-cycle latency is acceptable.

Parameters:
WIDTH, 8, data width in bits
SHW, 3, shift-amount width; equals clog2(WIDTH); legal amounts are 0..WIDTH-1

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  request present on di/amt/sel
in_ready  output  1  block can accept a request
di  input  WIDTH  operand
amt  input  SHW  shift amount
sel  input  2  mode: 00 logical left, 01 logical right, 10 rotate left, 11 rotate right
out_valid  output  1  result present on so
out_ready  input  1  consumer accepts the result
so  output  WIDTH  result word
busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, so=0, internal counter=0, mode register=00. Reset is sampled only on a clk edge and overrides every other input, including mid-shift and while holding a result; the pending request is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture di into the working register (drives so), capture sel and amt.
  - amt!=0: go to SHIFT with cnt=amt.
  - amt==0: go directly to DONE; so=di unchanged.
- SHIFT:
  - in_ready=0.
  - Each edge shifts the working register by exactly 1 position per the captured mode and decrements cnt.
  - Logical modes zero-fill the vacated bit. Rotate modes feed the exiting bit back into the vacated end.
  - On the edge where cnt goes 1->0, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - so and out_valid stay stable until out_ready=1 at an edge.
  - On that edge: out_valid=0, go to IDLE.
  - in_valid is ignored in DONE; there is no same-cycle re-accept, so the minimum request spacing is amt+2 cycles.
- Latency: with the acceptance edge as E0, out_valid is high after edge E(max(amt,0)), i.e. k cycles after acceptance for amt=k≥1, and the cycle right after acceptance for amt=0.
- Inputs di/amt/sel changing after acceptance have no effect; the captured copies are used.
- so is the working register. It is only meaningful while out_valid=1, but it is always deterministic, with no X after reset.
- amt is at most WIDTH-1 by width construction, so there is no overflow case.
- in_valid asserted during reset is ignored; the first acceptance occurs on the first edge with rst=0.

Test Plan:
- Reset, then di=8'b1001_0110, amt=3, sel=00 with out_ready=1 -> out_valid high 3 cycles after acceptance, so=8'b1011_0000, in_ready back to 1 the cycle after the output handshake.
- Same di, amt=3, sel=01 -> so=8'b0001_0010; sel=10 -> so=8'b1011_0100; di=8'b1001_0110, amt=1, sel=11 -> so=8'b0100_1011 after 1 cycle.
- amt=0, di=8'hA5, any sel -> out_valid the cycle after acceptance, so=8'hA5.
- Backpressure: di=8'h01, amt=7, sel=00, out_ready=0 for 5 cycles after out_valid -> so held at 8'h80, out_valid held 1, in_ready=0; a new in_valid during the hold is not accepted; out_ready=1 completes the transfer.
- Reset mid-operation: assert rst during SHIFT of a 7-step request -> next cycle state IDLE, so=0, out_valid=0, busy=0, in_ready=1; a subsequent request di=8'hFF, amt=4, sel=01 -> so=8'h0F.
- Walk all di=1..8 through each sel with amt=1, mirroring the combinational shifter sweep -> so matches the one-position shift/rotate of di for each mode.
